// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - regfile read port plus captured-word stream bundle
//
// Groups the signals that regfile_dump uses to talk to the regfile and to
// the debug/trace consumer.
//   rn     : regfile read-port index, driven by the dumper
//   q      : regfile read data for rn, combinational from the regfile
//   dout   : captured register value
//   didx   : index of the value on dout
//   dvalid : dout/didx valid
//   dready : consumer accepts the word when dvalid & dready at a clk edge
// master = dumper side, slave = regfile + consumer side.

interface regfile_dump_if;
    logic [4:0]  rn;
    logic [31:0] q;
    logic [31:0] dout;
    logic [4:0]  didx;
    logic        dvalid;
    logic        dready;

    modport master (
        output rn,
        input  q,
        output dout,
        output didx,
        output dvalid,
        input  dready
    );

    modport slave (
        input  rn,
        output q,
        input  dout,
        input  didx,
        input  dvalid,
        output dready
    );
endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - debug reader that streams a regfile index range out
//
// Walks START_IDX..END_IDX through one regfile read port and emits each
// captured 32-bit value with its index over a valid/ready handshake. Only
// the read side of the regfile is touched.
// Ports:
//   clk    : system clock, rising edge
//   clrn   : asynchronous active-low reset
//   start  : begin a dump, sampled only while idle
//   abort  : cancel a dump in progress
//   busy   : dump in progress
//   done   : one-cycle pulse after the last word is accepted
//   bus    : regfile read port and output word stream (master side)

module regfile_dump #(
    parameter int START_IDX = 0,
    parameter int END_IDX   = 31
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    regfile_dump_if.master        bus
);

    generate
        if (START_IDX < 0 || START_IDX > 31 || END_IDX < 0 || END_IDX > 31 ||
            START_IDX > END_IDX) begin : g_bad_range
            $error("regfile_dump: START_IDX/END_IDX must satisfy 0 <= START_IDX <= END_IDX <= 31");
        end
    endgenerate

    localparam logic [4:0] LP_START = 5'(START_IDX);
    localparam logic [4:0] LP_END   = 5'(END_IDX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t      r_state;
    logic [4:0]  r_rn;
    logic [31:0] r_dout;
    logic [4:0]  r_didx;
    logic        r_dvalid;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_nxt;
    logic [4:0]  w_rn_nxt;
    logic [31:0] w_dout_nxt;
    logic [4:0]  w_didx_nxt;
    logic        w_dvalid_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_hs;
    logic        w_last;

    assign w_hs   = r_dvalid & bus.dready;
    assign w_last = (r_rn == LP_END);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= ST_IDLE;
            r_rn     <= 5'd0;
            r_dout   <= 32'd0;
            r_didx   <= 5'd0;
            r_dvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rn     <= w_rn_nxt;
            r_dout   <= w_dout_nxt;
            r_didx   <= w_didx_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rn_nxt     = r_rn;
        w_dout_nxt   = r_dout;
        w_didx_nxt   = r_didx;
        w_dvalid_nxt = r_dvalid;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // start beats a simultaneous abort, and is honoured even on
                // the cycle where done is still pulsing.
                if (start) begin
                    w_rn_nxt    = LP_START;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (abort) begin
                    w_dvalid_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    // rn has been stable for this whole cycle, so q is the
                    // value as of before any write landing on this edge.
                    w_dout_nxt   = bus.q;
                    w_didx_nxt   = r_rn;
                    w_dvalid_nxt = 1'b1;
                    w_state_nxt  = ST_SEND;
                end
            end

            ST_SEND: begin
                // abort outranks a same-edge handshake: the word is dropped.
                if (abort) begin
                    w_dvalid_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else if (w_hs) begin
                    w_dvalid_nxt = 1'b0;
                    if (w_last) begin
                        // Stop here so rn never runs past END_IDX.
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_rn_nxt    = r_rn + 5'd1;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end

            default: begin
                w_dvalid_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    assign bus.rn     = r_rn;
    assign bus.dout   = r_dout;
    assign bus.didx   = r_didx;
    assign bus.dvalid = r_dvalid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump

module tb_regfile_dump;

    logic        clk;
    logic        clrn;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        start1;
    logic        abort1;
    logic        busy1;
    logic        done1;
    logic [31:0] regs [32];

    int n_total;
    int n_bad;

    regfile_dump_if bus0 ();
    regfile_dump_if bus1 ();

    assign bus0.q = (bus0.rn == 5'd0) ? 32'd0 : regs[bus0.rn];
    assign bus1.q = (bus1.rn == 5'd0) ? 32'd0 : regs[bus1.rn];

    regfile_dump #(.START_IDX(0), .END_IDX(31)) u_dut0 (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus0)
    );

    regfile_dump #(.START_IDX(1), .END_IDX(3)) u_dut1 (
        .clk   (clk),
        .clrn  (clrn),
        .start (start1),
        .abort (abort1),
        .busy  (busy1),
        .done  (done1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pre(input int i);
        logic [31:0] v;
        v = 32'h11111111 * 32'(i);
        return v;
    endfunction

    task automatic wait_word(input int idx);
        int c;
        c = 0;
        while (!(bus0.dvalid && bus0.didx == 5'(idx)) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_word", 64'(c < 200), 64'd1);
    endtask

    initial begin
        int          nexp;
        int          stall;
        int          donecnt;
        logic [15:0] lfsr;
        logic        prev_hold;
        logic [4:0]  prev_didx;
        logic [31:0] prev_dout;

        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < 32; i++) regs[i] = pre(i);
        clrn = 1'b0; start = 1'b0; abort = 1'b0; bus0.dready = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; bus1.dready = 1'b1;

        // reset state
        #12;
        chk("rst_rn",     64'(bus0.rn),     64'd0);
        chk("rst_dout",   64'(bus0.dout),   64'd0);
        chk("rst_didx",   64'(bus0.didx),   64'd0);
        chk("rst_dvalid", 64'(bus0.dvalid), 64'd0);
        chk("rst_busy",   64'(busy),        64'd0);
        chk("rst_done",   64'(done),        64'd0);
        @(negedge clk); clrn = 1'b1;
        @(negedge clk);

        // full dump, dready held high
        start = 1'b1; bus0.dready = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("t1_busy",   64'(busy),        64'd1);
        chk("t1_rn",     64'(bus0.rn),     64'd0);
        chk("t1_dvalid", 64'(bus0.dvalid), 64'd0);
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            chk("t1_valid", 64'(bus0.dvalid), 64'd1);
            chk("t1_didx",  64'(bus0.didx),   64'(n));
            chk("t1_dout",  64'(bus0.dout),   64'(pre(n)));
            @(negedge clk);
            chk("t1_gap",   64'(bus0.dvalid), 64'd0);
            chk("t1_done",  64'(done),        64'(n == 31));
            chk("t1_busyq", 64'(busy),        64'(n != 31));
        end
        @(negedge clk);
        chk("t1_done_end", 64'(done), 64'd0);

        // backpressure with a long stall on word 7
        lfsr = 16'hACE1; stall = 0; nexp = 0; prev_hold = 1'b0;
        prev_didx = 5'd0; prev_dout = 32'd0;
        bus0.dready = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 600 && nexp < 32; c++) begin
            if (prev_hold) begin
                chk("t2_hold_v", 64'(bus0.dvalid), 64'd1);
                chk("t2_hold_i", 64'(bus0.didx),   64'(prev_didx));
                chk("t2_hold_d", 64'(bus0.dout),   64'(prev_dout));
            end
            if (bus0.dvalid && bus0.didx == 5'd7 && stall < 5) begin
                bus0.dready = 1'b0;
                stall++;
            end else begin
                bus0.dready = lfsr[0];
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
            if (bus0.dvalid && bus0.dready) begin
                chk("t2_didx", 64'(bus0.didx), 64'(nexp));
                chk("t2_dout", 64'(bus0.dout), 64'(pre(nexp)));
                nexp++;
            end
            prev_hold = bus0.dvalid && !bus0.dready;
            prev_didx = bus0.didx;
            prev_dout = bus0.dout;
            @(negedge clk);
        end
        chk("t2_count", 64'(nexp),  64'd32);
        chk("t2_stall", 64'(stall), 64'd5);
        chk("t2_done",  64'(done),  64'd1);
        chk("t2_busy",  64'(busy),  64'd0);
        bus0.dready = 1'b1;
        @(negedge clk);
        chk("t2_done_end", 64'(done), 64'd0);

        // abort at didx 10 on a handshake edge
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_word(10);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t3_busy",   64'(busy),        64'd0);
        chk("t3_dvalid", 64'(bus0.dvalid), 64'd0);
        chk("t3_rn",     64'(bus0.rn),     64'd10);
        for (int c = 0; c < 3; c++) begin
            chk("t3_nodone", 64'(done), 64'd0);
            @(negedge clk);
        end

        // restart, then a start while busy at didx 5 is ignored
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("t4_first_v", 64'(bus0.dvalid), 64'd1);
        chk("t4_first_i", 64'(bus0.didx),   64'd0);
        chk("t4_first_d", 64'(bus0.dout),   64'd0);
        wait_word(5);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        nexp = 6; donecnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus0.dvalid) begin
                chk("t4_didx", 64'(bus0.didx), 64'(nexp));
                chk("t4_dout", 64'(bus0.dout), 64'(pre(nexp)));
                nexp++;
            end
            if (done) donecnt++;
            @(negedge clk);
        end
        chk("t4_count", 64'(nexp),    64'd32);
        chk("t4_dones", 64'(donecnt), 64'd1);
        chk("t4_busy",  64'(busy),    64'd0);

        // asynchronous reset mid-SEND
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_word(20);
        bus0.dready = 1'b0;
        #2 clrn = 1'b0;
        #1;
        chk("t5_rn",     64'(bus0.rn),     64'd0);
        chk("t5_dout",   64'(bus0.dout),   64'd0);
        chk("t5_didx",   64'(bus0.didx),   64'd0);
        chk("t5_dvalid", 64'(bus0.dvalid), 64'd0);
        chk("t5_busy",   64'(busy),        64'd0);
        chk("t5_done",   64'(done),        64'd0);
        @(negedge clk); clrn = 1'b1; bus0.dready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t5_quiet_v", 64'(bus0.dvalid), 64'd0);
            chk("t5_quiet_d", 64'(done),        64'd0);
        end

        // short range instance with a write racing the FETCH of index 2
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("t6_rn", 64'(bus1.rn), 64'd1);
        @(negedge clk);
        chk("t6_w1_v", 64'(bus1.dvalid), 64'd1);
        chk("t6_w1_i", 64'(bus1.didx),   64'd1);
        chk("t6_w1_d", 64'(bus1.dout),   64'h11111111);
        @(negedge clk);
        chk("t6_rn2", 64'(bus1.rn), 64'd2);
        @(posedge clk) regs[2] <= 32'hDEADBEEF;
        @(negedge clk);
        chk("t6_w2_v", 64'(bus1.dvalid), 64'd1);
        chk("t6_w2_i", 64'(bus1.didx),   64'd2);
        chk("t6_w2_d", 64'(bus1.dout),   64'h22222222);
        @(negedge clk);
        @(negedge clk);
        chk("t6_w3_v", 64'(bus1.dvalid), 64'd1);
        chk("t6_w3_i", 64'(bus1.didx),   64'd3);
        chk("t6_w3_d", 64'(bus1.dout),   64'h33333333);
        chk("t6_nodone", 64'(done1),     64'd0);
        @(negedge clk);
        chk("t6_done",  64'(done1),  64'd1);
        chk("t6_busy",  64'(busy1),  64'd0);
        chk("t6_rnend", 64'(bus1.rn), 64'd3);
        @(negedge clk);
        chk("t6_done_end", 64'(done1), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
